// File: rtl/dxor_serial_decoder.sv
// Bit-serial DXOR decoder: recovers x1=y1, x2=y1^y2 from LSB-first encoded
// bit pairs and presents WIDTH-bit words on a valid/ready output port.
module dxor_serial_decoder #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_y1,
  input  logic             in_y2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x1,
  output logic [WIDTH-1:0] out_x2,
  output logic             out_eq,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh1_reg, sh2_reg;
  logic [WIDTH-1:0] sh1_next, sh2_next;
  logic             accept;
  logic             last_bit;

  // In FULL the input may only advance when the held word retires this cycle.
  assign in_ready = (state == COLLECT) | out_ready;
  assign accept   = in_valid & in_ready;
  assign last_bit = (bit_cnt == CW'(WIDTH-1));

  assign sh1_next = {in_y1, sh1_reg[WIDTH-1:1]};
  assign sh2_next = {in_y1 ^ in_y2, sh2_reg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      sh1_reg   <= '0;
      sh2_reg   <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_x1    <= '0;
      out_x2    <= '0;
      out_eq    <= 1'b0;
    end else if (flush) begin
      state     <= COLLECT;
      sh1_reg   <= '0;
      sh2_reg   <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_x1    <= '0;
      out_x2    <= '0;
      out_eq    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            sh1_reg <= sh1_next;
            sh2_reg <= sh2_next;
            if (last_bit) begin
              // x1 == x2 exactly when every y2 bit of the word was zero
              out_x1    <= sh1_next;
              out_x2    <= sh2_next;
              out_eq    <= (sh1_next == sh2_next);
              out_valid <= 1'b1;
              bit_cnt   <= '0;
              state     <= FULL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
            if (accept) begin
              sh1_reg <= sh1_next;
              sh2_reg <= sh2_next;
              bit_cnt <= CW'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
